// File: rtl/truth_table_sweeper_pkg.sv
// Purpose: shared types and sizes for the truth-table sweeper and its hold timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int VEC_W   = 4;   // {a,b,c,d}
  localparam int NUM_VEC = 16;  // 2**VEC_W input combinations
  localparam int HOLD_W  = 8;   // wide enough for HOLD_CYCLES up to 255

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Purpose: per-vector dwell counter, counts 0..HOLD_CYCLES-1 and wraps.
// Latency: last is combinational from the registered count.
// Backpressure: none; enable gates counting, clear forces the count to 0.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        force count to 0 on the next edge (priority over enable)
//   enable       advance the count on the next edge
//   last         high while count == HOLD_CYCLES-1
module hold_timer
  import sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [HOLD_W-1:0] count;

  assign last = (count == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      // Wrap straight back to 0 so the next vector gets a full window.
      if (last) count <= '0;
      else      count <= count + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose: drives {a,b,c,d}=0..15 into a 4-input function, holds each vector
//          HOLD_CYCLES clocks, and captures f into a 16-bit truth table.
// Latency: 16*HOLD_CYCLES cycles of DRIVE after start, then one DONE cycle.
// Backpressure: none; start is only honoured in IDLE or DONE, never queued.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              level-sampled sweep request
//   a, b, c, d         registered stimulus, a is the MSB of the vector index
//   f                  output of the function under test
//   busy               high while vectors are being driven
//   done               one-cycle pulse after the final sample
//   response           bit i = f sampled while {a,b,c,d} = i
//   ones_count         population count of response (0..16)
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  input  logic                f,
  output logic                busy,
  output logic                done,
  output logic [NUM_VEC-1:0]  response,
  output logic [4:0]          ones_count
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("truth_table_sweeper: HOLD_CYCLES must be in 1..255");
  end

  state_t             state;
  logic [VEC_W-1:0]   index;
  logic               launch;
  logic               last;

  // A start seen in the DONE cycle launches the next sweep directly, so a
  // held start gives back-to-back sweeps with exactly one DONE cycle between
  // them. While DRIVE is running start is ignored.
  assign launch = start && ((state == IDLE) || (state == DONE));

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .enable (state == DRIVE),
    .last   (last)
  );

  // The index register is the stimulus itself, so {a,b,c,d} is registered.
  assign {a, b, c, d} = index;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      response   <= '0;
      ones_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state      <= DRIVE;
            index      <= '0;
            busy       <= 1'b1;
            response   <= '0;
            ones_count <= '0;
          end else begin
            state <= IDLE;
          end
        end

        DRIVE: begin
          // Sample at the end of the hold window so f has settled.
          if (last) begin
            response[index] <= f;
            ones_count      <= ones_count + 5'(f);
            if (index == VEC_W'(NUM_VEC - 1)) begin
              state <= DONE;
              index <= '0;   // park the stimulus at 0 during DONE/IDLE
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index <= index + VEC_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  // Instance g uses HOLD_CYCLES = g+1.
  logic            clk;
  logic [2:0]      rst;
  logic [2:0]      st;
  logic [2:0][15:0] tt;     // truth table of the modelled function per instance
  wire  [2:0][3:0]  vec;
  wire  [2:0]       fv;
  wire  [2:0]       bsy;
  wire  [2:0]       dn;
  wire  [2:0][15:0] rsp;
  wire  [2:0][4:0]  one;

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    truth_table_sweeper #(
      .HOLD_CYCLES (g + 1)
    ) dut (
      .clk        (clk),
      .reset      (rst[g]),
      .start      (st[g]),
      .a          (vec[g][3]),
      .b          (vec[g][2]),
      .c          (vec[g][1]),
      .d          (vec[g][0]),
      .f          (fv[g]),
      .busy       (bsy[g]),
      .done       (dn[g]),
      .response   (rsp[g]),
      .ones_count (one[g])
    );
    // Function under test: a lookup in the chosen truth table.
    assign fv[g] = tt[g][vec[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_vec",  32'(vec[s]), 0);
    chk("rst_busy", 32'(bsy[s]), 0);
    chk("rst_done", 32'(dn[s]),  0);
    chk("rst_rsp",  32'(rsp[s]), 0);
    chk("rst_ones", 32'(one[s]), 0);
  endtask

  // Full sweep on instance s with truth table t; optionally pokes start
  // while vector 6 is being driven. Entered and left at #1 after an edge.
  task automatic sweep(input int s, input logic [15:0] t, input bit poke);
    int          h;
    int          nb;
    logic [16:0] m;
    logic [15:0] part;
    h = s + 1;
    tt[s] = t;
    st[s] = 1'b1;
    @(posedge clk); #1;
    st[s] = 1'b0;
    for (int k = 0; k < 16 * h; k++) begin
      chk("sweep_vec",  32'(vec[s]), k / h);
      chk("sweep_busy", 32'(bsy[s]), 1);
      chk("sweep_done", 32'(dn[s]),  0);
      if (k % h == 0) begin
        nb   = k / h;
        m    = (17'd1 << nb) - 17'd1;
        part = t & m[15:0];
        chk("partial_rsp",  32'(rsp[s]), 32'(part));
        chk("partial_ones", 32'(one[s]), $countones(part));
      end
      st[s] = poke && (k == 6 * h);
      @(posedge clk); #1;
    end
    st[s] = 1'b0;
    chk("end_done", 32'(dn[s]),  1);
    chk("end_busy", 32'(bsy[s]), 0);
    chk("end_vec",  32'(vec[s]), 0);
    chk("end_rsp",  32'(rsp[s]), 32'(t));
    chk("end_ones", 32'(one[s]), $countones(t));
    @(posedge clk); #1;
    chk("idle_done", 32'(dn[s]),  0);
    chk("idle_busy", 32'(bsy[s]), 0);
    chk("idle_rsp",  32'(rsp[s]), 32'(t));
  endtask

  initial begin
    logic [15:0] t;
    int          s;
    int          p;

    rst = 3'b111;
    st  = 3'b000;
    tt  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 3'b000;
    for (int i = 0; i < 3; i++) chk_reset(i);

    // a&b and parity on H=2, constant 1 on H=1, constant 0 on H=3.
    sweep(1, 16'hF000, 1'b0);
    sweep(1, 16'h6996, 1'b0);
    sweep(0, 16'hFFFF, 1'b0);
    sweep(2, 16'h0000, 1'b0);

    // Random truth tables on random hold lengths.
    for (int r = 0; r < 4; r++) begin
      s = int'($urandom_range(0, 2));
      t = 16'($urandom);
      sweep(s, t, 1'b0);
    end

    // start pulsed mid-sweep must not restart or double the done pulse.
    sweep(1, 16'hF000, 1'b1);

    // Reset while vector 5 is driven discards the partial response.
    tt[1] = 16'hFFFF;
    st[1] = 1'b1;
    @(posedge clk); #1;
    st[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_vec", 32'(vec[1]), 5);
    chk("pre_reset_rsp", 32'(rsp[1]), 32'h001F);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk_reset(1);
    sweep(1, 16'hF000, 1'b0);

    // Reset wins over a simultaneous start.
    rst[1] = 1'b1;
    st[1]  = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    st[1]  = 1'b0;
    chk("rst_prio_busy", 32'(bsy[1]), 0);
    chk("rst_prio_rsp",  32'(rsp[1]), 0);

    // start held high: sweeps every 16*H+1 cycles, response cleared each time.
    t     = 16'($urandom);
    tt[1] = t;
    p     = 33;
    st[1] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3 * p; k++) begin
      chk("b2b_done", 32'(dn[1]), (k % p == 32) ? 1 : 0);
      if (k % p == 32) begin
        chk("b2b_rsp",  32'(rsp[1]), 32'(t));
        chk("b2b_ones", 32'(one[1]), $countones(t));
      end
      if (k % p == 0) begin
        chk("b2b_clear_rsp", 32'(rsp[1]), 0);
        chk("b2b_busy",      32'(bsy[1]), 1);
        chk("b2b_vec",       32'(vec[1]), 0);
      end
      if (k == 3 * p - 1) st[1] = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_stop_busy", 32'(bsy[1]), 0);
    chk("b2b_stop_done", 32'(dn[1]),  0);
    chk("b2b_stop_rsp",  32'(rsp[1]), 32'(t));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
